keyboard_renderer: RTL and testbench
====================================

# keyboard_renderer

- Draws a row of NUM_KEYS rectangular keys on the 160x120, 3-bit-colour VGA adapter.
- Each key is drawn in its press colour or in idle white, from a per-key pressed bitmask, so several keys can be shown pressed at once.
- Keeps a saved colour per key and, on each refresh, redraws only keys whose colour changed; a full redraw is forced at reset or on request.
- Sits between the key/audio control logic and the VGA adapter's x/y/colour/plot port.

## Interface
Parameters:
- NUM_KEYS, 7: number of keys (1..16).
- KEY_W, 8: key width in pixels (power of two not required).
- KEY_H, 64: key height in pixels.
- KEY_PITCH, 10: x distance between left edges of adjacent keys.
- X_ORIGIN, 40: screen x of key 0 left edge.
- Y_ORIGIN, 30: screen y of all key top edges.
- IDLE_COLOUR, 3'b111: colour of an unpressed key.

Ports:
- iClock  in  1  clock.
- iResetn  in  1  reset, synchronous, active-low.
- iKeys  in  NUM_KEYS  pressed bitmask; bit k=1 means key k pressed.
- iPressColour  in  3  colour for pressed keys.
- iRefresh  in  1  redraw request, sampled only in IDLE.
- iFull  in  1  with iRefresh, marks every key dirty.
- oX  out  8  pixel x.
- oY  out  7  pixel y.
- oColour  out  3  pixel colour.
- oPlot  out  1  pixel write enable, one pixel per cycle.
- oDone  out  1  high while in IDLE.

## Operation
- States: INIT, SCAN, DRAW, IDLE.
- INIT (reset state):
  - Saved colours = IDLE_COLOUR; target colours = IDLE_COLOUR; dirty = all ones.
  - Next state is SCAN.
- IDLE:
  - oDone=1.
  - On iRefresh=1, snapshot the targets: target[k] = iKeys[k] ? iPressColour : IDLE_COLOUR.
  - Set dirty[k] = iFull | (target[k] != saved[k]); next state is SCAN.
  - With iRefresh=0, stay in IDLE.
- SCAN:
  - Select the lowest-index dirty key into cur_key and clear the x/y counters; next state is DRAW.
  - If no key is dirty, next state is IDLE.
- DRAW:
  - oPlot=1.
  - oX = X_ORIGIN + cur_key*KEY_PITCH + xcnt; oY = Y_ORIGIN + ycnt; oColour = target[cur_key].
  - xcnt runs 0..KEY_W-1 and wraps, then ycnt increments (row-major).
  - On the last pixel (xcnt=KEY_W-1, ycnt=KEY_H-1): saved[cur_key] <= target[cur_key], dirty[cur_key] <= 0, next state is SCAN.
- Boundary conditions:
  - iKeys and iPressColour changes outside the IDLE accept cycle are ignored. Targets are frozen until the next accept.
  - iRefresh while busy is dropped, not queued.
  - iFull without iRefresh has no effect.
  - Reset mid-draw: the next cycle is INIT and a full redraw follows. Partially drawn pixels are overwritten.
- Width rules:
  - Coordinate sums are computed at 9 bits and truncated to 8/7 bits.
  - Elaboration check: X_ORIGIN+(NUM_KEYS-1)*KEY_PITCH+KEY_W <= 160 and Y_ORIGIN+KEY_H <= 120; otherwise $error.

## Timing
- Reset values (cycle after iResetn=0 sampled): oPlot=0, oDone=0, oX=X_ORIGIN, oY=Y_ORIGIN, oColour=IDLE_COLOUR.
- oX/oY/oColour are combinational from state and counters. They are valid in the same cycle as oPlot, and held at the reset values outside DRAW.
- Cycle t = state after the accepting edge:
  - Accept: IDLE, iRefresh=1, edge at t0.
  - t0+1: SCAN, oDone=0.
  - First pixel at t0+2.
- Redrawing one key takes KEY_W*KEY_H cycles of DRAW, plus one SCAN per key, plus one final SCAN.
- With m dirty keys, oDone returns at t0 + 1 + m*(KEY_W*KEY_H+1) + 1.
- With no dirty keys, oDone returns at t0+2 with zero plots.
- Full frame after reset: 3584 plot cycles at default parameters.

## Structure
- Package kb_pkg:
  - Colour constants WHITE, BLACK, GREEN.
  - SCREEN_W=160, SCREEN_H=120.
  - State enum kb_state_t.
- Sub-module rect_scanner:
  - Parametrised W/H x/y counter with clear, enable and a last flag.
  - Reused later for other rectangle fills.
- The priority "lowest dirty" selection is a function in kb_pkg.

## Test plan
- Reset, then hold iRefresh=0: exactly 3584 oPlot cycles with x 40..107, y 30..93, all colour 111; then oDone=1 and stays high.
- iKeys=0000100, iPressColour=010, iRefresh pulse: exactly 512 plots, all x 60..67, y 30..93, colour 010; oDone returns at t0+515.
- Repeat the same refresh with unchanged inputs: zero plots; oDone low only at t0+1 and high again at t0+2.
- iKeys=1000001, colour 100: key 0 is drawn fully (x 40..47) before key 6 (x 100..107); 1024 plots.
- iRefresh with iFull=1 and iKeys=0: 3584 plots.
- Toggle iKeys and pulse iRefresh mid-draw: drawing completes with the snapshot colours, and there is no extra redraw.
- Deassert iResetn for one cycle mid-draw: oPlot=0 next cycle, then a full 3584-plot white redraw.

Source files
------------

// File: rtl/keyboard_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kb_pkg
// Brief   : Shared colours, screen size, FSM states and dirty-key priority pick
// Rev     : 1.0
// ============================================================================
package kb_pkg;

   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] GREEN = 3'b010;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int MAX_KEYS = 16;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_SCAN = 2'd1,
      ST_DRAW = 2'd2,
      ST_IDLE = 2'd3
   } kb_state_t;

   // Index of the lowest set bit; zero when nothing is set.
   function automatic logic [3:0] lowest_dirty(input logic [MAX_KEYS-1:0] dirty);
      logic [3:0] idx;
      idx = '0;
      for (int k = MAX_KEYS - 1; k >= 0; k--) begin
         if (dirty[k]) idx = 4'(k);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keyboard_renderer_if.sv
`default_nettype none
// ============================================================================
// Module  : keyboard_renderer_if
// Brief   : Key/refresh control inputs and VGA pixel port of the renderer
// Rev     : 1.0
// ============================================================================
interface keyboard_renderer_if #(
   parameter int NUM_KEYS = 7
) ();

   logic [NUM_KEYS-1:0] iKeys;
   logic [2:0]          iPressColour;
   logic                iRefresh;
   logic                iFull;
   logic [7:0]          oX;
   logic [6:0]          oY;
   logic [2:0]          oColour;
   logic                oPlot;
   logic                oDone;

   modport master (
      output iKeys, iPressColour, iRefresh, iFull,
      input  oX, oY, oColour, oPlot, oDone
   );

   modport slave (
      input  iKeys, iPressColour, iRefresh, iFull,
      output oX, oY, oColour, oPlot, oDone
   );

endinterface
`default_nettype wire

// File: rtl/keyboard_renderer_scanner.sv
`default_nettype none
// ============================================================================
// Module  : rect_scanner
// Brief   : Row-major W x H pixel counter with clear, enable and last flag
// Rev     : 1.0
// ============================================================================
module rect_scanner #(
   parameter  int W  = 8,
   parameter  int H  = 64,
   localparam int XW = (W > 1) ? $clog2(W) : 1,
   localparam int YW = (H > 1) ? $clog2(H) : 1
) (
   input  wire logic          iClock,
   input  wire logic          iResetn,
   input  wire logic          i_clear,
   input  wire logic          i_enable,
   output logic      [XW-1:0] o_xcnt,
   output logic      [YW-1:0] o_ycnt,
   output logic               o_last
);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_x_end;
   logic          w_y_end;

   assign w_x_end = (r_x == XW'(W - 1));
   assign w_y_end = (r_y == YW'(H - 1));

   always_ff @(posedge iClock) begin
      if (!iResetn || i_clear) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_enable) begin
         if (w_x_end) begin
            r_x <= '0;
            r_y <= w_y_end ? '0 : r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   assign o_xcnt = r_x;
   assign o_ycnt = r_y;
   assign o_last = w_x_end && w_y_end;

endmodule
`default_nettype wire

// File: rtl/keyboard_renderer.sv
`default_nettype none
// ============================================================================
// Module  : keyboard_renderer
// Brief   : Draws a row of keys on the 160x120 VGA adapter, redrawing only
//           keys whose colour changed since they were last drawn
// Rev     : 1.0
// ============================================================================
module keyboard_renderer
   import kb_pkg::*;
#(
   parameter int         NUM_KEYS    = 7,
   parameter int         KEY_W       = 8,
   parameter int         KEY_H       = 64,
   parameter int         KEY_PITCH   = 10,
   parameter int         X_ORIGIN    = 40,
   parameter int         Y_ORIGIN    = 30,
   parameter logic [2:0] IDLE_COLOUR = WHITE
) (
   input  wire logic           iClock,
   input  wire logic           iResetn,
   keyboard_renderer_if.slave  bus
);

   localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int XW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
   localparam int YW = (KEY_H > 1) ? $clog2(KEY_H) : 1;

   generate
      if ((X_ORIGIN + (NUM_KEYS - 1) * KEY_PITCH + KEY_W > SCREEN_W) ||
          (Y_ORIGIN + KEY_H > SCREEN_H)) begin : g_geom_check
         $error("keyboard_renderer: key row does not fit on the screen");
      end
      if ((NUM_KEYS < 1) || (NUM_KEYS > MAX_KEYS)) begin : g_count_check
         $error("keyboard_renderer: NUM_KEYS must be 1..16");
      end
   endgenerate

   kb_state_t                     r_state;
   logic [NUM_KEYS-1:0][2:0]      r_saved;
   logic [NUM_KEYS-1:0][2:0]      r_target;
   logic [NUM_KEYS-1:0]           r_dirty;
   logic [KW-1:0]                 r_cur_key;
   logic                          r_plot;
   logic                          r_done;

   logic [NUM_KEYS-1:0][2:0]      w_snap_target;
   logic [NUM_KEYS-1:0]           w_snap_dirty;
   logic [XW-1:0]                 w_xcnt;
   logic [YW-1:0]                 w_ycnt;
   logic                          w_last;
   logic                          w_scan_clear;
   logic                          w_scan_en;
   logic [8:0]                    w_x_sum;
   logic [8:0]                    w_y_sum;

   assign w_scan_clear = (r_state == ST_SCAN);
   assign w_scan_en    = (r_state == ST_DRAW);

   rect_scanner #(
      .W (KEY_W),
      .H (KEY_H)
   ) u_scanner (
      .iClock   (iClock),
      .iResetn  (iResetn),
      .i_clear  (w_scan_clear),
      .i_enable (w_scan_en),
      .o_xcnt   (w_xcnt),
      .o_ycnt   (w_ycnt),
      .o_last   (w_last)
   );

   always_comb begin
      w_snap_target = '0;
      w_snap_dirty  = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         w_snap_target[k] = bus.iKeys[k] ? bus.iPressColour : IDLE_COLOUR;
         w_snap_dirty[k]  = bus.iFull || (w_snap_target[k] != r_saved[k]);
      end
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         r_state   <= ST_INIT;
         r_cur_key <= '0;
         r_plot    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               for (int k = 0; k < NUM_KEYS; k++) begin
                  r_saved[k]  <= IDLE_COLOUR;
                  r_target[k] <= IDLE_COLOUR;
               end
               r_dirty <= '1;
               r_plot  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (|r_dirty) begin
                  r_cur_key <= KW'(lowest_dirty(16'(r_dirty)));
                  r_plot    <= 1'b1;
                  r_state   <= ST_DRAW;
               end else begin
                  r_done    <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_DRAW: begin
               if (w_last) begin
                  r_saved[r_cur_key] <= r_target[r_cur_key];
                  r_dirty[r_cur_key] <= 1'b0;
                  r_plot             <= 1'b0;
                  r_state            <= ST_SCAN;
               end
            end
            ST_IDLE: begin
               // Targets are captured only here, so input changes during a draw are ignored.
               if (bus.iRefresh) begin
                  r_target <= w_snap_target;
                  r_dirty  <= w_snap_dirty;
                  r_done   <= 1'b0;
                  r_state  <= ST_SCAN;
               end
            end
            default: begin
               r_plot  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign w_x_sum = 9'(X_ORIGIN) + 9'(r_cur_key) * 9'(KEY_PITCH) + 9'(w_xcnt);
   assign w_y_sum = 9'(Y_ORIGIN) + 9'(w_ycnt);

   assign bus.oX      = (r_state == ST_DRAW) ? w_x_sum[7:0]        : 8'(X_ORIGIN);
   assign bus.oY      = (r_state == ST_DRAW) ? w_y_sum[6:0]        : 7'(Y_ORIGIN);
   assign bus.oColour = (r_state == ST_DRAW) ? r_target[r_cur_key] : IDLE_COLOUR;
   assign bus.oPlot   = r_plot;
   assign bus.oDone   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_renderer.sv
`default_nettype none
// ============================================================================
// Module  : tb_keyboard_renderer
// Brief   : Directed self-checking bench for keyboard_renderer
// Rev     : 1.0
// ============================================================================
module tb_keyboard_renderer;
   import kb_pkg::*;

   localparam int NK = 7;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   keyboard_renderer_if #(.NUM_KEYS(NK)) bus ();

   keyboard_renderer #(.NUM_KEYS(NK)) dut (
      .iClock  (clk),
      .iResetn (rstn),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int plots, done_at, done_first;
   int minx, maxx, miny, maxy;
   int col_err, shape_err, order_err, idle_err, hold_err;
   logic [2:0] exp_col [NK];

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_exp(input logic [NK-1:0] pressed, input logic [2:0] col);
      for (int k = 0; k < NK; k++) exp_col[k] = pressed[k] ? col : 3'b111;
   endtask

   // Runs from cycle t0 (current negedge); cycle n is the n-th following negedge.
   task automatic measure(input int act_cyc, input int limit);
      int   dx, dy, k, off;
      logic seen6;
      plots = 0; done_at = -1; done_first = -1;
      minx = 999; maxx = -1; miny = 999; maxy = -1;
      col_err = 0; shape_err = 0; order_err = 0; idle_err = 0;
      seen6 = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         if (cyc == 1) done_first = int'(bus.oDone);
         if (bus.oPlot) begin
            plots++;
            dx = int'(bus.oX) - 40;
            dy = int'(bus.oY);
            if (dx < 0) begin
               shape_err++;
            end else begin
               k   = dx / 10;
               off = dx % 10;
               if (k >= NK || off >= 8) shape_err++;
               else begin
                  if (bus.oColour != exp_col[k]) col_err++;
                  if (k == 6) seen6 = 1'b1;
                  if (k == 0 && seen6) order_err++;
               end
            end
            if (dy < 30 || dy > 93) shape_err++;
            if (int'(bus.oX) < minx) minx = int'(bus.oX);
            if (int'(bus.oX) > maxx) maxx = int'(bus.oX);
            if (dy < miny) miny = dy;
            if (dy > maxy) maxy = dy;
         end else if (bus.oX != 8'd40 || bus.oY != 7'd30 || bus.oColour != 3'b111) begin
            idle_err++;
         end
         if (cyc == 1) begin
            bus.iRefresh = 1'b0;
            bus.iFull    = 1'b0;
         end
         if (cyc == act_cyc) begin
            bus.iKeys        = '1;
            bus.iPressColour = 3'b001;
            bus.iRefresh     = 1'b1;
         end
         if (cyc == act_cyc + 1) bus.iRefresh = 1'b0;
         if (bus.oDone) begin
            done_at = cyc;
            break;
         end
      end
   endtask

   task automatic refresh(input logic [NK-1:0] keys, input logic [2:0] col,
                          input logic full, input int act_cyc, input int limit);
      bus.iKeys        = keys;
      bus.iPressColour = col;
      bus.iFull        = full;
      bus.iRefresh     = 1'b1;
      measure(act_cyc, limit);
   endtask

   task automatic hold_idle(input int n);
      hold_err = 0;
      repeat (n) begin
         @(negedge clk);
         if (!bus.oDone || bus.oPlot) hold_err++;
      end
   endtask

   initial begin
      bus.iKeys        = '0;
      bus.iPressColour = 3'b000;
      bus.iRefresh     = 1'b0;
      bus.iFull        = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_value("rst_plot",   int'(bus.oPlot),   0);
      check_value("rst_done",   int'(bus.oDone),   0);
      check_value("rst_x",      int'(bus.oX),      40);
      check_value("rst_y",      int'(bus.oY),      30);
      check_value("rst_colour", int'(bus.oColour), 7);

      // Power-up full white frame
      set_exp('0, 3'b000);
      rstn = 1'b1;
      measure(0, 5000);
      check_value("init_plots",  plots,     3584);
      check_value("init_minx",   minx,      40);
      check_value("init_maxx",   maxx,      107);
      check_value("init_miny",   miny,      30);
      check_value("init_maxy",   maxy,      93);
      check_value("init_colour", col_err,   0);
      check_value("init_shape",  shape_err, 0);
      check_value("init_idle",   idle_err,  0);
      check_value("init_done",   done_at,   3593);
      hold_idle(20);
      check_value("init_hold",   hold_err,  0);

      // Single key pressed green
      set_exp(7'b0000100, 3'b010);
      refresh(7'b0000100, 3'b010, 1'b0, 0, 5000);
      check_value("k2_plots",  plots,      512);
      check_value("k2_minx",   minx,       60);
      check_value("k2_maxx",   maxx,       67);
      check_value("k2_miny",   miny,       30);
      check_value("k2_maxy",   maxy,       93);
      check_value("k2_colour", col_err,    0);
      check_value("k2_busy",   done_first, 0);
      check_value("k2_done",   done_at,    515);

      // Unchanged refresh draws nothing
      refresh(7'b0000100, 3'b010, 1'b0, 0, 100);
      check_value("same_plots", plots,      0);
      check_value("same_busy",  done_first, 0);
      check_value("same_done",  done_at,    2);

      // iFull alone does nothing
      bus.iFull = 1'b1;
      hold_idle(10);
      bus.iFull = 1'b0;
      check_value("full_only_hold", hold_err, 0);

      // Forced full redraw, all released
      set_exp('0, 3'b000);
      refresh(7'b0000000, 3'b010, 1'b1, 0, 5000);
      check_value("full_plots",  plots,   3584);
      check_value("full_colour", col_err, 0);
      check_value("full_done",   done_at, 3593);

      // Two keys, ascending order
      set_exp(7'b1000001, 3'b100);
      refresh(7'b1000001, 3'b100, 1'b0, 0, 5000);
      check_value("two_plots",  plots,     1024);
      check_value("two_minx",   minx,      40);
      check_value("two_maxx",   maxx,      107);
      check_value("two_order",  order_err, 0);
      check_value("two_colour", col_err,   0);
      check_value("two_done",   done_at,   1028);

      // Inputs and refresh toggled mid-draw are ignored
      set_exp(7'b0000100, 3'b010);
      refresh(7'b0000100, 3'b010, 1'b0, 100, 5000);
      check_value("mid_plots",  plots,     1536);
      check_value("mid_colour", col_err,   0);
      check_value("mid_shape",  shape_err, 0);
      check_value("mid_done",   done_at,   1541);
      hold_idle(20);
      check_value("mid_no_extra", hold_err, 0);

      // Reset mid-draw restarts with a full white frame
      set_exp('0, 3'b000);
      refresh(7'b0000000, 3'b000, 1'b1, 0, 50);
      check_value("rstmid_drawing", int'(bus.oPlot), 1);
      rstn = 1'b0;
      @(negedge clk);
      check_value("rstmid_plot", int'(bus.oPlot), 0);
      check_value("rstmid_done", int'(bus.oDone), 0);
      check_value("rstmid_x",    int'(bus.oX),    40);
      rstn = 1'b1;
      measure(0, 5000);
      check_value("rstmid_plots",  plots,   3584);
      check_value("rstmid_colour", col_err, 0);
      check_value("rstmid_done2",  done_at, 3593);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
